vx_tb_bringup_seq: RTL

- Bring-up sequencer that drives the testbench top-level control bundle: per-subsystem resets, memory-loader handshake and the DCR write port.
- Sits directly upstream of the top interface. It releases the resets in dependency order: loader, then memory/arbiter, then caches. It runs the memory image load, programs the startup DCRs, and only then releases the core and global barrier.
- It replaces ad-hoc reset sequencing in the test and gives the UVM layer one done/error status pair.

---
 rtl/vx_tb_bringup_seq.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/vx_tb_bringup_seq.sv
// -----------------------------------------------------------------------------
// vx_tb_bringup_seq
//
// Bring-up sequencer for the testbench top-level control bundle. It holds every
// subsystem in reset, then releases the subsystems in dependency order:
//   loader -> memory load -> memory/arbiter -> caches -> DCR programming
//   -> core/global barrier.
// One done/error status pair summarises the outcome. The error is a loader
// timeout.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle request to run, or to re-run from RUN/ERROR
//   dcr_addrs, dcr_datas  packed DCR tables; entry i is in slice i
//   mem_loader_done       level from the memory loader, high when the load is done
//   *_reset               active-high subsystem resets (seven outputs)
//   load_mem              high while the load phase is active
//   start_mem_loader      single-cycle loader kick on the first LOAD cycle
//   dcr_write_*           DCR write port; the port has no backpressure
//   bringup_done          high in RUN
//   bringup_error         high in ERROR
//
// Every output is a register. Each output is written on the edge that enters a
// state, so a state entered at edge N shows its outputs from cycle N.
// -----------------------------------------------------------------------------
module vx_tb_bringup_seq #(
    parameter int DCR_ADDR_WIDTH    = 12,
    parameter int DCR_DATA_WIDTH    = 32,
    parameter int NUM_DCRS          = 3,
    parameter int RESET_HOLD_CYCLES = 8,
    parameter int RESET_GAP_CYCLES  = 2,
    parameter int LOADER_TIMEOUT    = 65536
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic [NUM_DCRS*DCR_ADDR_WIDTH-1:0] dcr_addrs,
    input  logic [NUM_DCRS*DCR_DATA_WIDTH-1:0] dcr_datas,
    input  logic                               mem_loader_done,
    output logic                               mem_load_reset,
    output logic                               mem_reset,
    output logic                               mem_arb_reset,
    output logic                               icache_reset,
    output logic                               dcache_reset,
    output logic                               core_reset,
    output logic                               gbar_reset,
    output logic                               load_mem,
    output logic                               start_mem_loader,
    output logic                               dcr_write_valid,
    output logic [DCR_ADDR_WIDTH-1:0]          dcr_write_addr,
    output logic [DCR_DATA_WIDTH-1:0]          dcr_write_data,
    output logic                               bringup_done,
    output logic                               bringup_error
);

    localparam int CNT_W = 17;
    localparam int IDX_W = 5;

    // Terminal counts. The counter starts at 0 on entry to a state, so the
    // last count is N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RESET_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOADER_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_END      = IDX_W'(NUM_DCRS);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HOLD      = 4'd1,
        ST_REL_LDR   = 4'd2,
        ST_LOAD      = 4'd3,
        ST_REL_MEM   = 4'd4,
        ST_REL_CACHE = 4'd5,
        ST_DCR_WR    = 4'd6,
        ST_REL_CORE  = 4'd7,
        ST_RUN       = 4'd8,
        ST_ERROR     = 4'd9
    } state_t;

    state_t                    state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [IDX_W-1:0]          idx_r;
    logic [DCR_ADDR_WIDTH-1:0] addr_sel_s;
    logic [DCR_DATA_WIDTH-1:0] data_sel_s;

    // Select DCR table entry idx_r from the live table inputs.
    always_comb begin
        addr_sel_s = {DCR_ADDR_WIDTH{1'b0}};
        data_sel_s = {DCR_DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_DCRS; i++) begin
            addr_sel_s = (idx_r == IDX_W'(i)) ? dcr_addrs[i*DCR_ADDR_WIDTH +: DCR_ADDR_WIDTH] : addr_sel_s;
            data_sel_s = (idx_r == IDX_W'(i)) ? dcr_datas[i*DCR_DATA_WIDTH +: DCR_DATA_WIDTH] : data_sel_s;
        end
    end

    // Sequencer FSM. Outputs are written on the transition edge into each state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            cnt_r            <= {CNT_W{1'b0}};
            idx_r            <= {IDX_W{1'b0}};
            mem_load_reset   <= 1'b1;
            mem_reset        <= 1'b1;
            mem_arb_reset    <= 1'b1;
            icache_reset     <= 1'b1;
            dcache_reset     <= 1'b1;
            core_reset       <= 1'b1;
            gbar_reset       <= 1'b1;
            load_mem         <= 1'b0;
            start_mem_loader <= 1'b0;
            dcr_write_valid  <= 1'b0;
            dcr_write_addr   <= {DCR_ADDR_WIDTH{1'b0}};
            dcr_write_data   <= {DCR_DATA_WIDTH{1'b0}};
            bringup_done     <= 1'b0;
            bringup_error    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            start_mem_loader <= 1'b0;
            dcr_write_valid  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_HOLD;
                        cnt_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r        <= ST_REL_LDR;
                        cnt_r          <= {CNT_W{1'b0}};
                        mem_load_reset <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 17'd1;
                    end
                end
                ST_REL_LDR: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r          <= ST_LOAD;
                        cnt_r            <= {CNT_W{1'b0}};
                        load_mem         <= 1'b1;
                        start_mem_loader <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 17'd1;
                    end
                end
                ST_LOAD: begin
                    // cnt_r == 0 is the entry cycle. A done level left over
                    // from before the kick is ignored there. Done has priority
                    // over a timeout in the same cycle.
                    if ((cnt_r != {CNT_W{1'b0}}) && mem_loader_done) begin
                        state_r       <= ST_REL_MEM;
                        cnt_r         <= {CNT_W{1'b0}};
                        load_mem      <= 1'b0;
                        mem_reset     <= 1'b0;
                        mem_arb_reset <= 1'b0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r       <= ST_ERROR;
                        cnt_r         <= {CNT_W{1'b0}};
                        load_mem      <= 1'b0;
                        bringup_error <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 17'd1;
                    end
                end
                ST_REL_MEM: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r      <= ST_REL_CACHE;
                        cnt_r        <= {CNT_W{1'b0}};
                        icache_reset <= 1'b0;
                        dcache_reset <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 17'd1;
                    end
                end
                ST_REL_CACHE: begin
                    // Write 0 is issued on the entry edge of DCR_WR (idx_r is 0 here).
                    if (cnt_r == GAP_LAST) begin
                        state_r         <= ST_DCR_WR;
                        cnt_r           <= {CNT_W{1'b0}};
                        dcr_write_valid <= 1'b1;
                        dcr_write_addr  <= addr_sel_s;
                        dcr_write_data  <= data_sel_s;
                        idx_r           <= idx_r + 5'd1;
                    end else begin
                        cnt_r <= cnt_r + 17'd1;
                    end
                end
                ST_DCR_WR: begin
                    // idx_r is the next write to issue. Addr/data keep their
                    // last value after the final write.
                    if (idx_r == IDX_END) begin
                        state_r    <= ST_REL_CORE;
                        core_reset <= 1'b0;
                        gbar_reset <= 1'b0;
                    end else begin
                        dcr_write_valid <= 1'b1;
                        dcr_write_addr  <= addr_sel_s;
                        dcr_write_data  <= data_sel_s;
                        idx_r           <= idx_r + 5'd1;
                    end
                end
                ST_REL_CORE: begin
                    state_r      <= ST_RUN;
                    bringup_done <= 1'b1;
                end
                ST_RUN, ST_ERROR: begin
                    if (start) begin
                        state_r        <= ST_HOLD;
                        cnt_r          <= {CNT_W{1'b0}};
                        idx_r          <= {IDX_W{1'b0}};
                        mem_load_reset <= 1'b1;
                        mem_reset      <= 1'b1;
                        mem_arb_reset  <= 1'b1;
                        icache_reset   <= 1'b1;
                        dcache_reset   <= 1'b1;
                        core_reset     <= 1'b1;
                        gbar_reset     <= 1'b1;
                        load_mem       <= 1'b0;
                        bringup_done   <= 1'b0;
                        bringup_error  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule
